// File: rtl/uart_tx_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_feeder
// Purpose  : Byte FIFO that feeds a UART transmitter one byte at a time using
//            a load strobe / holding-register-empty handshake.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
    parameter int DEPTH = 16,   // FIFO depth in bytes, power of two, 2..256
    parameter int AW    = 4     // pointer width, log2(DEPTH)
) (
    input  logic          txclk,
    input  logic          reset,       // asynchronous, active low
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    input  logic          ovf_clr,
    input  logic          enable,
    input  logic          tx_empty,
    output logic          ld_tx_data,
    output logic [7:0]    tx_data,
    output logic          tx_enable
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // full comes straight from the registered level, so a pop in the same
    // cycle never opens room for a push into a full FIFO.
    assign full = (level == LEVEL_FULL);
    assign push = wr_en && !full;
    // The head byte leaves the FIFO at the end of the single LOAD cycle.
    assign pop  = (state == LOAD);

    // Storage array: written on accepted pushes only, contents need no reset
    // because the pointers and level define what is valid.
    always_ff @(posedge txclk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // Sticky overflow flag; a refusal wins over a coincident clear.
    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    // Transmitter enable follows the enable input one cycle later.
    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            tx_enable <= 1'b0;
        end else begin
            tx_enable <= enable;
        end
    end

    // Load handshake FSM: capture head byte, strobe for one cycle, then wait
    // for the UART to signal it has taken the byte before considering another.
    always_ff @(posedge txclk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ld_tx_data <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            ld_tx_data <= 1'b0;
            case (state)
                IDLE: begin
                    if ((level != '0) && tx_empty && enable) begin
                        tx_data    <= mem[rd_ptr];
                        ld_tx_data <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    state <= ACK;
                end
                ACK: begin
                    if (!tx_empty) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_feeder
// Purpose  : Scoreboard bench for uart_tx_feeder with a simple UART model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          txclk      = 1'b0;
    logic          reset      = 1'b0;
    logic          wr_en      = 1'b0;
    logic [7:0]    wr_data    = 8'h00;
    logic          ovf_clr    = 1'b0;
    logic          enable     = 1'b0;
    logic          man_empty  = 1'b1;
    logic          uart_auto  = 1'b0;
    logic          model_empty = 1'b1;
    logic          tx_empty;
    logic          full;
    logic [AW:0]   level;
    logic          overflow;
    logic          ld_tx_data;
    logic [7:0]    tx_data;
    logic          tx_enable;

    int            checks      = 0;
    int            errors      = 0;
    int            cyc         = 0;
    int            busy_len    = 10;
    int            model_cnt   = 0;
    int            last_strobe = -1000;
    logic [7:0]    exp_q [$];

    assign tx_empty = uart_auto ? model_empty : man_empty;

    uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .txclk      (txclk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .level      (level),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .enable     (enable),
        .tx_empty   (tx_empty),
        .ld_tx_data (ld_tx_data),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable)
    );

    always #5 txclk = ~txclk;

    // Cycle counter used for strobe spacing.
    always @(posedge txclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // UART model: tx_empty drops one cycle after a strobe, returns busy_len cycles later.
    always @(negedge txclk) begin
        if (model_cnt > 0) begin
            model_cnt = model_cnt - 1;
            if (model_cnt == busy_len) model_empty = 1'b0;
            if (model_cnt == 0)        model_empty = 1'b1;
        end
        if (ld_tx_data) model_cnt = busy_len + 1;
    end

    // Monitor: every load strobe must carry the oldest pending byte.
    always @(negedge txclk) begin
        logic [7:0] e;
        if (reset && ld_tx_data) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: tx_data=0x%0h with no byte pending (cycle %0d)", tx_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("tx_data_order", {24'h0, tx_data}, {24'h0, e});
            end
            if (uart_auto) chk("strobe_after_tx_empty", 32'(cyc - last_strobe >= busy_len + 2), 32'd1);
            last_strobe = cyc;
        end
    end

    task automatic tick();
        @(posedge txclk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge txclk);
            n++;
        end
        #1;
        chk("drain_done", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge txclk);
        @(negedge txclk);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_ld", ld_tx_data, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_enable", tx_enable, 0);
        tick(); reset = 1'b1;
        tick();

        // Single byte latency: push in N, strobe in N+2
        enable = 1'b1; man_empty = 1'b1;
        push_byte(8'hA5, 1'b1);
        tick(); wr_en = 1'b0;
        @(negedge txclk);
        chk("lat_level_n1", level, 1);
        chk("lat_ld_n1", ld_tx_data, 0);
        chk("tx_enable_on", tx_enable, 1);
        tick();
        @(negedge txclk);
        chk("lat_ld_n2", ld_tx_data, 1);
        tick();
        @(negedge txclk);
        chk("lat_level_after_pop", level, 0);
        chk("lat_ld_n3", ld_tx_data, 0);
        tick(); man_empty = 1'b0;
        tick(); man_empty = 1'b1;
        tick();

        // Fill with transmission disabled, 17th byte refused
        enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            push_byte(8'(8'h10 + i), i < 16);
            tick();
        end
        wr_en = 1'b0;
        @(negedge txclk);
        chk("fill_full", full, 1);
        chk("fill_level", level, 16);
        chk("fill_overflow", overflow, 1);
        tick(); ovf_clr = 1'b1;
        tick(); ovf_clr = 1'b0;
        @(negedge txclk);
        chk("ovf_cleared", overflow, 0);
        chk("ovf_clr_level", level, 16);
        tick(); push_byte(8'hCC, 1'b0); ovf_clr = 1'b1;
        tick(); wr_en = 1'b0; ovf_clr = 1'b0;
        @(negedge txclk);
        chk("ovf_refusal_wins", overflow, 1);
        chk("ovf_refusal_level", level, 16);
        chk("tx_enable_off", tx_enable, 0);
        tick(); ovf_clr = 1'b1;
        tick(); ovf_clr = 1'b0;
        @(negedge txclk);
        chk("ovf_cleared2", overflow, 0);

        // Push into full FIFO during the LOAD cycle
        tick(); enable = 1'b1;
        tick(); push_byte(8'hEE, 1'b0);
        @(negedge txclk);
        chk("full_load_ld", ld_tx_data, 1);
        chk("full_load_full", full, 1);
        tick(); wr_en = 1'b0; uart_auto = 1'b1;
        @(negedge txclk);
        chk("full_load_level", level, 15);
        chk("full_load_overflow", overflow, 1);
        tick(); ovf_clr = 1'b1;
        tick(); ovf_clr = 1'b0;
        wait_drain(400);
        repeat (15) tick();
        chk("drain1_level", level, 0);

        // Three bytes back to back with a slow UART
        push_byte(8'h01, 1'b1); tick();
        push_byte(8'h02, 1'b1); tick();
        push_byte(8'h03, 1'b1); tick();
        wr_en = 1'b0;
        wait_drain(100);
        repeat (15) tick();

        // 40 bytes through a fast UART, pointers wrap
        busy_len = 1;
        for (int i = 0; i < 40; i++) begin
            push_byte(8'(i * 37 + 5), 1'b1);
            tick(); wr_en = 1'b0;
            tick();
        end
        wait_drain(300);
        repeat (5) tick();
        @(negedge txclk);
        chk("wrap_level", level, 0);
        chk("wrap_overflow", overflow, 0);

        // Reset while in ACK with 5 bytes queued
        tick();
        busy_len = 10; uart_auto = 1'b0; man_empty = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_byte(8'(8'h60 + i), 1'b1);
            tick();
        end
        wr_en = 1'b0;
        @(negedge txclk);
        chk("ack_level", level, 5);
        chk("ack_ld", ld_tx_data, 0);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ld", ld_tx_data, 0);
        chk("mid_rst_tx_data", tx_data, 8'h00);
        chk("mid_rst_tx_enable", tx_enable, 0);
        exp_q.delete();
        tick(); tick(); reset = 1'b1;
        @(negedge txclk);
        chk("post_rst_ld", ld_tx_data, 0);
        repeat (20) tick();
        @(negedge txclk);
        chk("post_rst_level", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
